// File: rtl/axis_tx_pkg.sv
// Shared defaults and types for the paced AXI-Stream sample transmitter.
package axis_tx_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 16;
  localparam int DIV_W_DEF  = 16;

  // Transmit sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACE = 2'd1,
    HOLD = 2'd2
  } tx_state_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_sample_tx_if.sv
// AXI-Stream data channel carrying one sample per transfer.
interface axis_sample_tx_if
  import axis_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);

endinterface

// File: rtl/axis_tx_fifo.sv
// Single-clock sample FIFO with registered level/full and a
// combinational head so a pop can be captured in the same cycle.
module axis_tx_fifo
  import axis_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic [lvl_w(DEPTH)-1:0]  level,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [LW-1:0]     level_reg;
  logic [LW-1:0]     level_next;
  logic              full_reg;
  logic              push_ok;
  logic              pop_ok;

  // A push while full is dropped even if a pop frees a slot this cycle,
  // so the decision only looks at the registered full flag.
  assign push_ok = push && !full_reg;
  assign pop_ok  = pop && (level_reg != '0);

  // Sample storage; the head is read asynchronously so the sequencer
  // can move it into the output register on the tick cycle.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Next occupancy from accepted push/pop; both together leave it unchanged.
  always_comb begin
    level_next = level_reg;
    case ({push_ok, pop_ok})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  // Pointer, level and full registers; pointers wrap at DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      level_reg <= level_next;
      full_reg  <= (level_next == LW'(DEPTH));
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign level = level_reg;
  assign full  = full_reg;

endmodule

// File: rtl/axis_sample_tx.sv
// Paced sample transmitter: buffers samples in a FIFO and releases one
// onto an AXI-Stream master each time the programmable pace counter ticks.
module axis_sample_tx
  import axis_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     enable,
  input  logic [DIV_W-1:0]         pace_div,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_full,
  output logic [lvl_w(DEPTH)-1:0]  level,
  axis_sample_tx_if.master         m_axis_data,
  input  logic                     clr_flags,
  output logic                     overflow,
  output logic                     underrun,
  output logic                     late
);

  localparam int LW = lvl_w(DEPTH);

  tx_state_t         state_reg;
  tx_state_t         state_next;
  logic [DIV_W-1:0]  cnt_reg;
  logic [DIV_W-1:0]  cnt_next;
  logic              tick;
  logic              handshake;
  logic              pop;
  logic              overflow_set;
  logic              underrun_set;
  logic              late_set;
  logic              overflow_reg;
  logic              underrun_reg;
  logic              late_reg;
  logic [DATA_W-1:0] tdata_reg;
  logic [DATA_W-1:0] fifo_head;
  logic [LW-1:0]     fifo_level;
  logic              fifo_full;

  axis_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (aclk),
    .srst      (areset),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .head      (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full)
  );

  // Tick fires in the enabled cycle where the countdown sits at zero,
  // so pace_div=0 ticks on every enabled cycle.
  assign tick      = enable && (cnt_reg == '0);
  assign handshake = (state_reg == HOLD) && m_axis_data.tready;

  // Countdown: reload (sampling pace_div) when stopped or on a tick.
  always_comb begin
    cnt_next = cnt_reg - DIV_W'(1);
    if (!enable || tick) begin
      cnt_next = pace_div;
    end
  end

  // Pace counter register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_reg <= pace_div;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // Sequencer next state, pop request and error-flag set terms.
  // A tick arriving in IDLE (only possible with pace_div=0 on the very
  // first enabled cycle) is serviced like one in PACE so no tick is lost.
  always_comb begin
    state_next   = state_reg;
    pop          = 1'b0;
    underrun_set = 1'b0;
    late_set     = 1'b0;
    case (state_reg)
      IDLE, PACE: begin
        if (tick) begin
          if (fifo_level != '0) begin
            pop        = 1'b1;
            state_next = HOLD;
          end else begin
            underrun_set = 1'b1;
            state_next   = PACE;
          end
        end else if (enable) begin
          state_next = PACE;
        end else begin
          state_next = IDLE;
        end
      end
      HOLD: begin
        late_set = tick;
        if (handshake) begin
          state_next = enable ? PACE : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Output sample register: loaded from the FIFO head on the pop cycle,
  // held unchanged while waiting for the downstream handshake.
  always_ff @(posedge aclk) begin
    if (areset) begin
      tdata_reg <= '0;
    end else if (pop) begin
      tdata_reg <= fifo_head;
    end
  end

  assign overflow_set = wr_en && fifo_full;

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge aclk) begin
    if (areset) begin
      overflow_reg <= 1'b0;
      underrun_reg <= 1'b0;
      late_reg     <= 1'b0;
    end else begin
      overflow_reg <= overflow_set | (overflow_reg & ~clr_flags);
      underrun_reg <= underrun_set | (underrun_reg & ~clr_flags);
      late_reg     <= late_set     | (late_reg     & ~clr_flags);
    end
  end

  assign m_axis_data.tvalid = (state_reg == HOLD);
  assign m_axis_data.tdata  = tdata_reg;
  assign wr_full            = fifo_full;
  assign level              = fifo_level;
  assign overflow           = overflow_reg;
  assign underrun           = underrun_reg;
  assign late               = late_reg;

endmodule

// File: tb/tb_axis_sample_tx.sv
// Self-checking bench for axis_sample_tx: directed scenarios plus a
// randomized run, all compared cycle by cycle with a queue-based model.
module tb_axis_sample_tx;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int DIV_W  = 16;

  logic              aclk = 1'b0;
  logic              areset;
  logic              enable;
  logic [DIV_W-1:0]  pace_div;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              clr_flags;
  logic              wr_full;
  logic [4:0]        level;
  logic              overflow;
  logic              underrun;
  logic              late;

  axis_sample_tx_if #(.DATA_W(DATA_W)) m_axis_data ();

  axis_sample_tx #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .DIV_W  (DIV_W)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .enable      (enable),
    .pace_div    (pace_div),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_full     (wr_full),
    .level       (level),
    .m_axis_data (m_axis_data),
    .clr_flags   (clr_flags),
    .overflow    (overflow),
    .underrun    (underrun),
    .late        (late)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state
  logic [DATA_W-1:0] q_m[$];
  bit                pend_m;
  logic [DATA_W-1:0] data_m;
  bit                ovf_m, und_m, late_m;
  int                elapsed_m, period_m;

  // Observed transfers
  logic [DATA_W-1:0] emitted[$];
  int                emit_cyc[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Behavioural reference: one call per clock edge, using current inputs.
  task automatic model_step();
    bit tick, hs, pop;
    int lvl;
    if (areset) begin
      q_m.delete();
      pend_m = 0; data_m = '0;
      ovf_m = 0; und_m = 0; late_m = 0;
      elapsed_m = 0; period_m = int'(pace_div);
      return;
    end
    lvl  = q_m.size();
    tick = enable && (elapsed_m == period_m);
    hs   = pend_m && m_axis_data.tready;
    pop  = tick && !pend_m && (lvl > 0);
    ovf_m  = (wr_en && lvl == DEPTH) || (ovf_m && !clr_flags);
    und_m  = (tick && !pend_m && lvl == 0) || (und_m && !clr_flags);
    late_m = (tick && pend_m) || (late_m && !clr_flags);
    if (pop) begin
      data_m = q_m.pop_front();
      pend_m = 1;
    end else if (hs) begin
      pend_m = 0;
    end
    if (wr_en && lvl < DEPTH) q_m.push_back(wr_data);
    if (!enable || tick) begin
      elapsed_m = 0;
      period_m  = int'(pace_div);
    end else begin
      elapsed_m++;
    end
  endtask

  task automatic compare_all();
    check_val("tvalid",   32'(m_axis_data.tvalid), 32'(pend_m));
    check_val("tdata",    32'(m_axis_data.tdata),  32'(data_m));
    check_val("level",    32'(level),              32'(q_m.size()));
    check_val("wr_full",  32'(wr_full),            32'(q_m.size() == DEPTH));
    check_val("overflow", 32'(overflow),           32'(ovf_m));
    check_val("underrun", 32'(underrun),           32'(und_m));
    check_val("late",     32'(late),               32'(late_m));
  endtask

  // One clock: record any transfer, advance model, compare after the edge.
  task automatic cycle();
    if (m_axis_data.tvalid === 1'b1 && m_axis_data.tready === 1'b1) begin
      emitted.push_back(m_axis_data.tdata);
      emit_cyc.push_back(cyc);
      $display("xfer cyc=%0d tdata=%04h", cyc, m_axis_data.tdata);
    end
    model_step();
    @(posedge aclk);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic set_idle();
    enable = 0; wr_en = 0; wr_data = '0; clr_flags = 0;
    m_axis_data.tready = 0;
  endtask

  task automatic do_reset();
    set_idle();
    areset = 1;
    cycle();
    cycle();
    areset = 0;
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    wr_en = 1; wr_data = d;
    cycle();
    wr_en = 0;
  endtask

  task automatic wait_tvalid(input int max_cyc);
    int n = 0;
    while (m_axis_data.tvalid !== 1'b1 && n < max_cyc) begin
      cycle();
      n++;
    end
    check_val("tvalid_timeout", 32'(m_axis_data.tvalid), 32'd1);
  endtask

  initial begin
    areset = 1; pace_div = '0;
    set_idle();

    // Reset state
    do_reset();
    check_val("rst_tvalid", 32'(m_axis_data.tvalid), 32'd0);
    check_val("rst_level",  32'(level), 32'd0);

    // Steady pacing, pace_div=3
    do_reset();
    pace_div = 16'd3;
    m_axis_data.tready = 1;
    for (int i = 1; i <= 3; i++) push(DATA_W'(i));
    emitted.delete(); emit_cyc.delete();
    enable = 1;
    repeat (14) cycle();
    check_val("pace_count", 32'(emitted.size()), 32'd3);
    if (emitted.size() == 3) begin
      for (int i = 0; i < 3; i++) check_val("pace_data", 32'(emitted[i]), 32'(i + 1));
      check_val("pace_gap1", 32'(emit_cyc[1] - emit_cyc[0]), 32'd4);
      check_val("pace_gap2", 32'(emit_cyc[2] - emit_cyc[1]), 32'd4);
    end
    check_val("pace_flags", 32'({overflow, underrun, late}), 32'd0);

    // Fill to full and overflow, pace_div=0
    do_reset();
    pace_div = 16'd0;
    for (int i = 0; i < 17; i++) push(DATA_W'(16'h0100 + i));
    check_val("full_level", 32'(level), 32'd16);
    check_val("full_flag",  32'(wr_full), 32'd1);
    check_val("full_ovf",   32'(overflow), 32'd1);
    emitted.delete(); emit_cyc.delete();
    m_axis_data.tready = 1;
    enable = 1;
    repeat (40) cycle();
    check_val("drain_count", 32'(emitted.size()), 32'd16);
    if (emitted.size() == 16) check_val("drain_last", 32'(emitted[15]), 32'h010F);

    // Underrun on empty FIFO, then clear
    do_reset();
    pace_div = 16'd2;
    enable = 1;
    repeat (3) cycle();
    check_val("und_set",    32'(underrun), 32'd1);
    check_val("und_tvalid", 32'(m_axis_data.tvalid), 32'd0);
    enable = 0; clr_flags = 1;
    cycle();
    clr_flags = 0;
    check_val("und_clr", 32'(underrun), 32'd0);

    // Back-pressure: held sample, late flag, single transfer
    do_reset();
    pace_div = 16'd1;
    push(16'h8000);
    enable = 1;
    wait_tvalid(10);
    for (int i = 0; i < 6; i++) begin
      cycle();
      check_val("bp_tvalid", 32'(m_axis_data.tvalid), 32'd1);
      check_val("bp_tdata",  32'(m_axis_data.tdata), 32'h8000);
    end
    check_val("bp_late", 32'(late), 32'd1);
    emitted.delete(); emit_cyc.delete();
    m_axis_data.tready = 1;
    cycle();
    enable = 0;
    repeat (3) cycle();
    check_val("bp_count", 32'(emitted.size()), 32'd1);
    if (emitted.size() == 1) check_val("bp_data", 32'(emitted[0]), 32'h8000);

    // Enable dropped while holding
    do_reset();
    pace_div = 16'd1;
    push(16'h1111);
    push(16'h2222);
    enable = 1;
    wait_tvalid(10);
    enable = 0;
    repeat (4) cycle();
    check_val("dis_hold", 32'(m_axis_data.tvalid), 32'd1);
    emitted.delete(); emit_cyc.delete();
    m_axis_data.tready = 1;
    repeat (11) cycle();
    check_val("dis_count", 32'(emitted.size()), 32'd1);
    check_val("dis_tvalid", 32'(m_axis_data.tvalid), 32'd0);
    check_val("dis_level", 32'(level), 32'd1);

    // Reset while holding with samples buffered
    do_reset();
    pace_div = 16'd1;
    for (int i = 0; i < 6; i++) push(DATA_W'(16'h0A00 + i));
    enable = 1;
    wait_tvalid(10);
    check_val("rh_level", 32'(level), 32'd5);
    areset = 1;
    cycle();
    areset = 0;
    check_val("rh_tvalid", 32'(m_axis_data.tvalid), 32'd0);
    check_val("rh_level0", 32'(level), 32'd0);
    check_val("rh_flags",  32'({overflow, underrun, late}), 32'd0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) pace_div = DIV_W'($urandom_range(0, 5));
      areset             = ($urandom_range(0, 199) == 0);
      enable             = ($urandom_range(0, 9) < 8);
      wr_en              = ($urandom_range(0, 9) < 4);
      wr_data            = DATA_W'($urandom);
      m_axis_data.tready = ($urandom_range(0, 9) < 6);
      clr_flags          = ($urandom_range(0, 19) == 0);
      cycle();
    end
    set_idle();
    areset = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
